// File: rtl/chs_ramp_controller.sv
// chs_ramp_controller: ramps cooler/heater power toward a popcount target, draining to zero before any mode change
module chs_ramp_controller #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       conf_valid,
  input  logic [7:0] conf_data,
  output logic       conf_ready,
  output logic [3:0] act_power,
  output logic       act_mode,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RAMP, DRAIN, HOLD} state_t;
  state_t state, state_n;
  logic [7:0] tick, tick_n;
  logic [3:0] tgt_power, tgt_power_n, power_n, pop, ramp_val;
  logic tgt_mode, tgt_mode_n, mode_n, done_n, accept, step;
  assign conf_ready = state == IDLE || state == HOLD;
  assign busy = state == RAMP || state == DRAIN;
  assign accept = conf_valid && conf_ready;
  assign step = tick == 8'(TICK_DIV - 1);
  assign pop = 4'($countones(conf_data));
  assign ramp_val = tgt_power > act_power ? act_power + 4'd1 : act_power - 4'd1;
  always_comb begin
    state_n = state;
    power_n = act_power;
    mode_n = act_mode;
    tgt_power_n = tgt_power;
    tgt_mode_n = tgt_mode;
    tick_n = 8'd0;
    done_n = 1'b0;
    if (accept) begin
      tgt_power_n = pop;
      tgt_mode_n = conf_data[0];
      if (conf_data[0] != act_mode && act_power != 4'd0) begin
        state_n = DRAIN;
      end else begin
        // mode may only change here because power is already zero
        mode_n = conf_data[0];
        if (pop == act_power) begin
          state_n = pop == 4'd0 ? IDLE : HOLD;
          done_n = 1'b1;
        end else begin
          state_n = RAMP;
        end
      end
    end else if (busy) begin
      tick_n = step ? 8'd0 : tick + 8'd1;
      if (step && state == DRAIN) begin
        power_n = act_power - 4'd1;
        if (act_power == 4'd1) begin
          mode_n = tgt_mode;
          state_n = tgt_power == 4'd0 ? IDLE : RAMP;
          done_n = tgt_power == 4'd0;
        end
      end else if (step) begin
        power_n = ramp_val;
        if (ramp_val == tgt_power) begin
          state_n = tgt_power == 4'd0 ? IDLE : HOLD;
          done_n = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tick <= 8'd0;
      act_power <= 4'd0;
      act_mode <= 1'b0;
      tgt_power <= 4'd0;
      tgt_mode <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      act_power <= power_n;
      act_mode <= mode_n;
      tgt_power <= tgt_power_n;
      tgt_mode <= tgt_mode_n;
      done <= done_n;
    end
  end
endmodule

// File: doc/chs_ramp_controller.md
CHS_RAMP_CONTROLLER -- requirements
Module: chs_ramp_controller

Interface
REQ-001 Parameter TICK_DIV, default 4: clock cycles per actuator power step; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 conf_valid  input  1  new temperature configuration offered.
REQ-005 conf_data  input  8  configuration word; target power = count of ones, target mode = bit 0.
REQ-006 conf_ready  output  1  controller can accept a configuration this cycle.
REQ-007 act_power  output  4  power currently applied to cooler/heater, 0..8.
REQ-008 act_mode  output  1  mode currently applied: heat=1, cool=0.
REQ-009 busy  output  1  high while a ramp or drain is in progress.
REQ-010 done  output  1  one-cycle pulse: applied power and mode have reached the accepted target.

Function
REQ-011 Handshake SHALL occur on a rising edge where conf_valid=1 and conf_ready=1; conf_data SHALL be sampled only then.
REQ-012 conf_ready SHALL be 1 in IDLE and HOLD and 0 in RAMP and DRAIN; conf_valid while conf_ready=0 SHALL be ignored, with no effect on state.
REQ-013 On acceptance, tgt_power SHALL be popcount(conf_data), 4 bits, 0..8, and tgt_mode SHALL be conf_data[0]; both held until the next acceptance.
REQ-014 States: IDLE (act_power=0, no target pending), RAMP (stepping act_power toward tgt_power), DRAIN (stepping act_power down to 0 before a mode change), HOLD (act_power=tgt_power>0, act_mode=tgt_mode).
REQ-015 Acceptance with tgt_mode=act_mode and tgt_power=act_power SHALL go to HOLD, or to IDLE if tgt_power=0. It SHALL pulse done on the next cycle, with no output change.
REQ-016 Acceptance with tgt_mode differs from act_mode and act_power>0 SHALL go to DRAIN.
REQ-017 Acceptance with tgt_mode differs from act_mode and act_power=0 SHALL load act_mode=tgt_mode on the acceptance edge. It SHALL then go to RAMP, or follow REQ-015 if tgt_power=0.
REQ-018 All other acceptances SHALL go to RAMP.
REQ-019 Tick counter: cleared to 0 on every acceptance. In RAMP and DRAIN it SHALL increment each cycle and generate a step, then return to 0, when it equals TICK_DIV-1. It SHALL be held at 0 in IDLE and HOLD.
REQ-020 RAMP step: act_power SHALL change by exactly +1 or -1 toward tgt_power; no overshoot, no wrap past 0 or 8.
REQ-021 DRAIN step: act_power SHALL decrement by 1.
REQ-022 On the DRAIN step that makes act_power 0, act_mode SHALL load tgt_mode on the same edge. The state SHALL then go to RAMP, or to IDLE if tgt_power=0.
REQ-023 When a RAMP step makes act_power equal tgt_power, the state SHALL go to HOLD, or to IDLE if tgt_power=0.
REQ-024 done SHALL be 1 for exactly the one cycle after the edge that completes a target (REQ-015, REQ-022, REQ-023), and 0 otherwise.
REQ-025 busy SHALL be 1 exactly when the state is RAMP or DRAIN.
REQ-026 act_mode SHALL never change while act_power is nonzero.
REQ-027 Latency from acceptance to done SHALL be (|steps| x TICK_DIV) + 1 cycles, where steps = DRAIN steps + RAMP steps; TICK_DIV=1 SHALL step every cycle.

Reset
REQ-028 While rst_n=0, independent of clk: state=IDLE, act_power=0, act_mode=0, tick counter=0, tgt_power=0, tgt_mode=0, done=0, busy=0, conf_ready=1.
REQ-029 Reset asserted mid-RAMP or mid-DRAIN SHALL abort immediately to the REQ-028 values; no done pulse SHALL be emitted.
REQ-030 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification (TICK_DIV=4)
REQ-031 Release reset -> act_power=0, act_mode=0, conf_ready=1, busy=0, done=0.
REQ-032 From reset, accept 0x0F -> act_mode=1 at acceptance. act_power steps 1,2,3,4 at cycles 4,8,12,16 after acceptance. done pulses at cycle 17, then HOLD.
REQ-033 In HOLD(4, heat), accept 0x1E (pop 4, mode 0) -> DRAIN 3,2,1,0, with act_mode=0 on the edge reaching 0. Then RAMP 1..4; done 33 cycles after acceptance; act_mode never toggles while act_power>0.
REQ-034 In HOLD(4, cool), accept 0x1E again -> no output change; done pulses on the next cycle.
REQ-035 During a RAMP, hold conf_valid=1 with conf_data=0xFF -> conf_ready=0 and no effect. Original target completes; 0xFF is accepted on the first HOLD cycle and ramps to 8.
REQ-036 Assert rst_n=0 at act_power=2 mid-RAMP -> outputs immediately become 0/0, no done; normal operation after release.
